dac_spi_streamer: RTL and testbench

Output stage downstream of the dual-channel waveform generator. Captures a signed 16-bit sample pair (`wave_a`, `wave_b`) on each sample strobe and converts both values to offset binary. Serialises them as two 24-bit SPI write frames to a dual-channel 16-bit DAC, then pulses LDAC so both channels update simultaneously. It also reports busy and overrun status to the control logic.

---
 rtl/dac_spi_streamer.sv | 250 +++++++++++++++++++++++++
 tb/tb_dac_spi_streamer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_streamer.sv
// Dual-channel DAC output stage: captures a signed sample pair, sends two 24-bit SPI frames, then pulses LDAC.
// Optional gain scaling stage is enabled with the DAC_SPI_STREAMER_GAIN_EN macro.
module dac_spi_streamer #(
  parameter int         SCLK_DIV  = 4,
  parameter int         CS_GAP    = 2,
  parameter logic [3:0] CMD_WRITE = 4'h1,
  parameter logic [3:0] ADDR_A    = 4'b0001,
  parameter logic [3:0] ADDR_B    = 4'b1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic signed [15:0] wave_a,
  input  logic signed [15:0] wave_b,
`ifdef DAC_SPI_STREAMER_GAIN_EN
  input  logic        [15:0] gain_a,
  input  logic        [15:0] gain_b,
`endif
  input  logic               overrun_clr,
  output logic               busy,
  output logic               overrun,
  output logic               dac_sclk,
  output logic               dac_cs_n,
  output logic               dac_mosi,
  output logic               dac_ldac_n
);

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef DAC_SPI_STREAMER_GAIN_EN
    ST_SCALE,
`endif
    ST_FRAME_A,
    ST_GAP_A,
    ST_FRAME_B,
    ST_GAP_B,
    ST_LDAC
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(SCLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);
  localparam logic [15:0] LDAC_LAST = 16'(2 * SCLK_DIV - 1);

  state_t      state_r, state_nxt_s;
  logic [15:0] cnt_r, cnt_nxt_s;
  logic [4:0]  bit_r, bit_nxt_s;
  logic [23:0] shift_r, shift_nxt_s;
  logic [23:0] frame_b_r, frame_b_nxt_s;
  logic [23:0] frame_a_s, frame_b_s;
  logic        busy_r, overrun_r, sclk_r, cs_n_r, mosi_r, ldac_n_r;
  logic        overrun_nxt_s, sclk_nxt_s, cs_n_nxt_s, mosi_nxt_s, ldac_n_nxt_s;

`ifdef DAC_SPI_STREAMER_GAIN_EN
  logic [15:0] wa_r, wb_r, ga_r, gb_r;

  // Q1.15 gain multiply with floor shift and saturation to the signed 16-bit range.
  function automatic logic [15:0] sat_scale(input logic [15:0] w, input logic [15:0] g);
    logic signed [32:0] prod;
    logic signed [32:0] shifted;
    prod    = $signed({{17{w[15]}}, w}) * $signed({17'd0, g});
    shifted = prod >>> 15;
    if (shifted > 33'sd32767) begin
      sat_scale = 16'h7FFF;
    end else if (shifted < -33'sd32768) begin
      sat_scale = 16'h8000;
    end else begin
      sat_scale = shifted[15:0];
    end
  endfunction

  // Capture samples and gains on an accepted strobe; SCALE consumes them next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wa_r <= 16'h0000;
      wb_r <= 16'h0000;
      ga_r <= 16'h0000;
      gb_r <= 16'h0000;
    end else if (state_r == ST_IDLE && sample_valid) begin
      wa_r <= wave_a;
      wb_r <= wave_b;
      ga_r <= gain_a;
      gb_r <= gain_b;
    end else begin
      wa_r <= wa_r;
      wb_r <= wb_r;
      ga_r <= ga_r;
      gb_r <= gb_r;
    end
  end
`endif

  // Frame words: command, address, offset-binary data.
  always_comb begin
`ifdef DAC_SPI_STREAMER_GAIN_EN
    frame_a_s = {CMD_WRITE, ADDR_A, sat_scale(wa_r, ga_r) ^ 16'h8000};
    frame_b_s = {CMD_WRITE, ADDR_B, sat_scale(wb_r, gb_r) ^ 16'h8000};
`else
    frame_a_s = {CMD_WRITE, ADDR_A, wave_a ^ 16'h8000};
    frame_b_s = {CMD_WRITE, ADDR_B, wave_b ^ 16'h8000};
`endif
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_nxt_s     = bit_r;
    shift_nxt_s   = shift_r;
    frame_b_nxt_s = frame_b_r;
    sclk_nxt_s    = sclk_r;
    cs_n_nxt_s    = cs_n_r;
    mosi_nxt_s    = mosi_r;
    ldac_n_nxt_s  = ldac_n_r;

    if (sample_valid && state_r != ST_IDLE) begin
      overrun_nxt_s = 1'b1;
    end else if (overrun_clr) begin
      overrun_nxt_s = 1'b0;
    end else begin
      overrun_nxt_s = overrun_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (sample_valid) begin
`ifdef DAC_SPI_STREAMER_GAIN_EN
          state_nxt_s   = ST_SCALE;
`else
          state_nxt_s   = ST_FRAME_A;
          shift_nxt_s   = frame_a_s;
          frame_b_nxt_s = frame_b_s;
          cs_n_nxt_s    = 1'b0;
          mosi_nxt_s    = frame_a_s[23];
          cnt_nxt_s     = 16'd0;
          bit_nxt_s     = 5'd0;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
`ifdef DAC_SPI_STREAMER_GAIN_EN
      ST_SCALE: begin
        state_nxt_s   = ST_FRAME_A;
        shift_nxt_s   = frame_a_s;
        frame_b_nxt_s = frame_b_s;
        cs_n_nxt_s    = 1'b0;
        mosi_nxt_s    = frame_a_s[23];
        cnt_nxt_s     = 16'd0;
        bit_nxt_s     = 5'd0;
      end
`endif
      ST_FRAME_A, ST_FRAME_B: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nxt_s = 16'd0;
          if (!sclk_r) begin
            sclk_nxt_s = 1'b1;
          end else begin
            sclk_nxt_s = 1'b0;
            if (bit_r == 5'd23) begin
              cs_n_nxt_s  = 1'b1;
              mosi_nxt_s  = 1'b0;
              state_nxt_s = (state_r == ST_FRAME_A) ? ST_GAP_A : ST_GAP_B;
            end else begin
              bit_nxt_s   = bit_r + 5'd1;
              shift_nxt_s = {shift_r[22:0], 1'b0};
              mosi_nxt_s  = shift_r[22];
            end
          end
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_GAP_A: begin
        if (cnt_r == GAP_LAST) begin
          cnt_nxt_s   = 16'd0;
          bit_nxt_s   = 5'd0;
          shift_nxt_s = frame_b_r;
          mosi_nxt_s  = frame_b_r[23];
          cs_n_nxt_s  = 1'b0;
          state_nxt_s = ST_FRAME_B;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_GAP_B: begin
        if (cnt_r == GAP_LAST) begin
          cnt_nxt_s    = 16'd0;
          ldac_n_nxt_s = 1'b0;
          state_nxt_s  = ST_LDAC;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_LDAC: begin
        if (cnt_r == LDAC_LAST) begin
          cnt_nxt_s    = 16'd0;
          ldac_n_nxt_s = 1'b1;
          state_nxt_s  = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        cnt_nxt_s    = 16'd0;
        sclk_nxt_s   = 1'b0;
        cs_n_nxt_s   = 1'b1;
        mosi_nxt_s   = 1'b0;
        ldac_n_nxt_s = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      bit_r     <= 5'd0;
      shift_r   <= 24'd0;
      frame_b_r <= 24'd0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
      sclk_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      mosi_r    <= 1'b0;
      ldac_n_r  <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_r     <= bit_nxt_s;
      shift_r   <= shift_nxt_s;
      frame_b_r <= frame_b_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      overrun_r <= overrun_nxt_s;
      sclk_r    <= sclk_nxt_s;
      cs_n_r    <= cs_n_nxt_s;
      mosi_r    <= mosi_nxt_s;
      ldac_n_r  <= ldac_n_nxt_s;
    end
  end

  assign busy       = busy_r;
  assign overrun    = overrun_r;
  assign dac_sclk   = sclk_r;
  assign dac_cs_n   = cs_n_r;
  assign dac_mosi   = mosi_r;
  assign dac_ldac_n = ldac_n_r;

endmodule

// File: tb/tb_dac_spi_streamer.sv
// Scoreboard bench for dac_spi_streamer: default-timing and fast-timing instances share one SPI monitor.
module tb_dac_spi_streamer;

`ifdef DAC_SPI_STREAMER_GAIN_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sv_d = 1'b0, sv_f = 1'b0, clr_d = 1'b0, clr_f = 1'b0;
  logic signed [15:0] wave_a = 16'sd0, wave_b = 16'sd0;
`ifdef DAC_SPI_STREAMER_GAIN_EN
  logic [15:0] gain_a = 16'h8000, gain_b = 16'h8000;
`endif
  logic d_busy, d_ovr, d_sclk, d_cs_n, d_mosi, d_ldac_n;
  logic f_busy, f_ovr, f_sclk, f_cs_n, f_mosi, f_ldac_n;
  logic sel_fast = 1'b0;
  logic m_busy, m_sclk, m_cs_n, m_mosi, m_ldac_n;

  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] exp_frame_q[$];
  int          exp_busy_q[$];
  int          exp_ldac_q[$];

  always #5 clk = ~clk;

  dac_spi_streamer #(.SCLK_DIV(4), .CS_GAP(2)) dut (
    .clk(clk), .rst(rst), .sample_valid(sv_d), .wave_a(wave_a), .wave_b(wave_b),
`ifdef DAC_SPI_STREAMER_GAIN_EN
    .gain_a(gain_a), .gain_b(gain_b),
`endif
    .overrun_clr(clr_d), .busy(d_busy), .overrun(d_ovr), .dac_sclk(d_sclk),
    .dac_cs_n(d_cs_n), .dac_mosi(d_mosi), .dac_ldac_n(d_ldac_n)
  );

  dac_spi_streamer #(.SCLK_DIV(1), .CS_GAP(1)) dut_fast (
    .clk(clk), .rst(rst), .sample_valid(sv_f), .wave_a(wave_a), .wave_b(wave_b),
`ifdef DAC_SPI_STREAMER_GAIN_EN
    .gain_a(gain_a), .gain_b(gain_b),
`endif
    .overrun_clr(clr_f), .busy(f_busy), .overrun(f_ovr), .dac_sclk(f_sclk),
    .dac_cs_n(f_cs_n), .dac_mosi(f_mosi), .dac_ldac_n(f_ldac_n)
  );

  assign m_busy   = sel_fast ? f_busy   : d_busy;
  assign m_sclk   = sel_fast ? f_sclk   : d_sclk;
  assign m_cs_n   = sel_fast ? f_cs_n   : d_cs_n;
  assign m_mosi   = sel_fast ? f_mosi   : d_mosi;
  assign m_ldac_n = sel_fast ? f_ldac_n : d_ldac_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_xfer(input logic [23:0] fa, input logic [23:0] fb, input int busy_len, input int ldac_len);
    exp_frame_q.push_back(fa);
    exp_frame_q.push_back(fb);
    exp_busy_q.push_back(busy_len);
    exp_ldac_q.push_back(ldac_len);
  endtask

  task automatic strobe(input logic fast, input logic [15:0] a, input logic [15:0] b, input logic clr);
    @(negedge clk);
    wave_a = a;
    wave_b = b;
    clr_d  = clr;
    if (fast) sv_f = 1'b1;
    else      sv_d = 1'b1;
    @(negedge clk);
    sv_d  = 1'b0;
    sv_f  = 1'b0;
    clr_d = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (m_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (m_busy) begin
      n_err++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  // Monitor: reassembles frames on SCLK rising edges and measures busy/LDAC pulse widths.
  initial begin : monitor
    logic [23:0] sh;
    logic [23:0] exp_f;
    int   nbits, busy_len, ldac_len, exp_n;
    logic in_frame, prev_sclk;
    sh = 24'd0; nbits = 0; busy_len = 0; ldac_len = 0; in_frame = 1'b0; prev_sclk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0; nbits = 0; busy_len = 0; ldac_len = 0; prev_sclk = 1'b0;
      end else begin
        if (!m_cs_n) begin
          if (!in_frame) begin
            in_frame = 1'b1; nbits = 0; sh = 24'd0;
          end
          if (m_sclk && !prev_sclk) begin
            sh = {sh[22:0], m_mosi};
            nbits++;
          end
        end else if (in_frame) begin
          in_frame = 1'b0;
          check("frame_rising_edges", nbits, 24);
          n_cmp++;
          if (exp_frame_q.size() == 0) begin
            n_err++;
            $display("FAIL frame_unexpected: got frame 0x%06h, expected no frame", sh);
          end else begin
            exp_f = exp_frame_q.pop_front();
            if (sh !== exp_f) begin
              n_err++;
              $display("FAIL frame_data: got 0x%06h, expected 0x%06h", sh, exp_f);
            end
          end
        end
        if (!m_ldac_n) ldac_len++;
        else if (ldac_len != 0) begin
          n_cmp++;
          if (exp_ldac_q.size() == 0) begin
            n_err++;
            $display("FAIL ldac_unexpected: got pulse of %0d cycles, expected none", ldac_len);
          end else begin
            exp_n = exp_ldac_q.pop_front();
            if (ldac_len != exp_n) begin
              n_err++;
              $display("FAIL ldac_width: got %0d cycles, expected %0d", ldac_len, exp_n);
            end
          end
          ldac_len = 0;
        end
        if (m_busy) busy_len++;
        else if (busy_len != 0) begin
          n_cmp++;
          if (exp_busy_q.size() == 0) begin
            n_err++;
            $display("FAIL busy_unexpected: got busy of %0d cycles, expected none", busy_len);
          end else begin
            exp_n = exp_busy_q.pop_front();
            if (busy_len != exp_n) begin
              n_err++;
              $display("FAIL busy_width: got %0d cycles, expected %0d", busy_len, exp_n);
            end
          end
          busy_len = 0;
        end
        prev_sclk = m_sclk;
      end
    end
  end

  initial begin : stimulus
    #12;
    check("rst_cs_n", d_cs_n, 1);
    check("rst_ldac_n", d_ldac_n, 1);
    check("rst_sclk", d_sclk, 0);
    check("rst_mosi", d_mosi, 0);
    check("rst_busy", d_busy, 0);
    check("rst_overrun", d_ovr, 0);
    check("rst_fast_cs_n", f_cs_n, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic full-scale frames
    expect_xfer(24'h11FFFF, 24'h180000, 396 + EXTRA, 8);
    strobe(1'b0, 16'h7FFF, 16'h8000, 1'b0);
    wait_idle("basic");
    repeat (3) @(negedge clk);
    check("basic_overrun", d_ovr, 0);

    // Dropped strobe keeps the first pair
    expect_xfer(24'h119234, 24'h182BCD, 396 + EXTRA, 8);
    strobe(1'b0, 16'h1234, 16'hABCD, 1'b0);
    repeat (48) @(negedge clk);
    strobe(1'b0, 16'h5555, 16'hAAAA, 1'b0);
    check("overrun_set", d_ovr, 1);
    wait_idle("overrun");
    repeat (3) @(negedge clk);
    check("overrun_sticky", d_ovr, 1);
    @(negedge clk);
    clr_d = 1'b1;
    @(negedge clk);
    clr_d = 1'b0;
    check("overrun_clear", d_ovr, 0);

    // Clear coincident with a drop: set wins
    expect_xfer(24'h118100, 24'h187F00, 396 + EXTRA, 8);
    strobe(1'b0, 16'h0100, 16'hFF00, 1'b0);
    repeat (20) @(negedge clk);
    strobe(1'b0, 16'h0000, 16'h0000, 1'b1);
    check("overrun_set_wins", d_ovr, 1);
    wait_idle("set_wins");
    repeat (3) @(negedge clk);

    // Fast timing, back-to-back strobe on the first idle cycle
    sel_fast = 1'b1;
    repeat (2) @(negedge clk);
    expect_xfer(24'h118001, 24'h187FFF, 100 + EXTRA, 2);
    expect_xfer(24'h110001, 24'h18FFFE, 100 + EXTRA, 2);
    strobe(1'b1, 16'h0001, 16'hFFFF, 1'b0);
    wait_idle("fast_first");
    wave_a = 16'sh8001;
    wave_b = 16'sh7FFE;
    sv_f   = 1'b1;
    @(negedge clk);
    sv_f   = 1'b0;
    check("fast_b2b_accept", f_busy, 1);
    check("fast_b2b_overrun", f_ovr, 0);
    wait_idle("fast_second");
    repeat (3) @(negedge clk);
    check("fast_overrun_end", f_ovr, 0);
    sel_fast = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during frame A bit 10
    strobe(1'b0, 16'h1111, 16'h2222, 1'b0);
    repeat (84) @(negedge clk);
    check("midframe_cs_low", d_cs_n, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_cs_n", d_cs_n, 1);
    check("midrst_sclk", d_sclk, 0);
    check("midrst_mosi", d_mosi, 0);
    check("midrst_busy", d_busy, 0);
    check("midrst_ldac_n", d_ldac_n, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_ldac_n", d_ldac_n, 1);
    check("post_rst_busy", d_busy, 0);
    expect_xfer(24'h118000, 24'h188000, 396 + EXTRA, 8);
    strobe(1'b0, 16'h0000, 16'h0000, 1'b0);
    wait_idle("post_rst");
    repeat (3) @(negedge clk);

`ifdef DAC_SPI_STREAMER_GAIN_EN
    gain_a = 16'h8000;
    gain_b = 16'h8000;
    expect_xfer(24'h11C000, 24'h188000, 397, 8);
    strobe(1'b0, 16'h4000, 16'h0000, 1'b0);
    wait_idle("gain_unity");
    repeat (3) @(negedge clk);
    gain_a = 16'hFFFF;
    gain_b = 16'hFFFF;
    expect_xfer(24'h11FFFF, 24'h180000, 397, 8);
    strobe(1'b0, 16'h7FFF, 16'h8000, 1'b0);
    wait_idle("gain_sat");
    repeat (3) @(negedge clk);
    gain_a = 16'h8000;
    gain_b = 16'h8000;
`endif

    check("frames_left", exp_frame_q.size(), 0);
    check("busy_left", exp_busy_q.size(), 0);
    check("ldac_left", exp_ldac_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
